// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 keyboard host port.
package ps2_pkg;

  localparam logic [1:0] ADR_DATA = 2'b00;
  localparam logic [1:0] ADR_STAT = 2'b10;

  localparam logic [7:0] CMD_KBD_DIS = 8'hAD;
  localparam logic [7:0] CMD_KBD_EN  = 8'hAE;

  localparam int ST_OBF = 0;
  localparam int ST_IBF = 1;
  localparam int ST_SYS = 2;
  localparam int ST_EN  = 4;
  localparam int ST_OVF = 7;

  // Kind of bus access decoded in the request cycle
  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_RD_DATA,
    ACC_RD_STAT,
    ACC_WR_STAT,
    ACC_OTHER
  } wb_acc_e;

  // Assemble the 8042-style status byte; the input buffer is never busy
  function automatic logic [7:0] status_byte(input logic obf, input logic sys,
                                             input logic en, input logic ov);
    logic [7:0] s;
    s         = 8'h00;
    s[ST_OBF] = obf;
    s[ST_IBF] = 1'b0;
    s[ST_SYS] = sys;
    s[ST_EN]  = en;
    s[ST_OVF] = ov;
    return s;
  endfunction

endpackage

// File: rtl/ps2_kbd_fifo.sv
// Byte FIFO between the scancode strobe and the host data port.
// Head is read combinationally; a push while full is accepted only when a
// pop happens in the same cycle (the slot being vacated is reused).
module ps2_kbd_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [7:0]  mem [0:(1<<AW)-1];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until pointed at, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_kbd_port.sv
// 8042-style keyboard port: scancode FIFO behind a Wishbone slave with a
// data port (0x60), status/command port (0x64) and a level IRQ1 source.
// Accesses are acked one cycle after the request; their side effects
// (pop, ovf clear, enable/disable) are committed during the ack cycle.
module ps2_kbd_port
  import ps2_pkg::*;
#(
  parameter int   FIFO_AW    = 4,
  parameter logic STATUS_SYS = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         scancode,
  input  logic               rx_output_strobe,
  input  logic [1:0]         wb_adr_i,
  input  logic [15:0]        wb_dat_i,
  output logic [15:0]        wb_dat_o,
  input  logic [1:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_stb_i,
  input  logic               wb_cyc_i,
  output logic               wb_ack_o,
  output logic               kbd_irq,
  output logic [FIFO_AW:0]   fifo_level
);

  logic [7:0]        fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              kbd_en;
  logic              ovf;
  logic [7:0]        data_hold;
  logic              pend_pop;
  logic              pend_clr_ovf;
  logic              pend_dis;
  logic              pend_en;
  logic              push_ok;
  logic              pop_ok;
  logic              drop;
  logic [FIFO_AW:0]  level_nxt;
  logic              kbd_en_nxt;
  logic              ovf_nxt;
  logic              irq_nxt;
  logic [15:0]       dat_nxt;
  wb_acc_e           acc;
  logic              unused_bits;

  assign unused_bits = &{1'b0, wb_dat_i[15:8], wb_sel_i[1]};

  ps2_kbd_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_ok),
    .pop     (pop_ok),
    .din     (scancode),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Classify a new request; the ack cycle itself is never a new request
  always_comb begin
    acc = ACC_NONE;
    if (wb_stb_i && wb_cyc_i && !wb_ack_o) begin
      if (!wb_sel_i[0])                            acc = ACC_OTHER;
      else if (!wb_we_i && wb_adr_i == ADR_DATA)   acc = ACC_RD_DATA;
      else if (!wb_we_i && wb_adr_i == ADR_STAT)   acc = ACC_RD_STAT;
      else if (wb_we_i && wb_adr_i == ADR_STAT)    acc = ACC_WR_STAT;
      else                                         acc = ACC_OTHER;
    end
  end

  // Read data captured in the request cycle so it is stable during ack
  always_comb begin
    dat_nxt = 16'h0000;
    case (acc)
      ACC_RD_DATA: dat_nxt = {8'h00, fifo_empty ? data_hold : fifo_head};
      ACC_RD_STAT: dat_nxt = {8'h00, status_byte(~fifo_empty, STATUS_SYS, kbd_en, ovf)};
      default:     dat_nxt = 16'h0000;
    endcase
  end

  // FIFO handshakes and next values of the control state
  always_comb begin
    pop_ok     = pend_pop & ~fifo_empty;
    push_ok    = rx_output_strobe & kbd_en & (~fifo_full | pop_ok);
    drop       = rx_output_strobe & kbd_en & fifo_full & ~pop_ok;
    level_nxt  = fifo_level + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop_ok);
    kbd_en_nxt = kbd_en;
    if (pend_dis)     kbd_en_nxt = 1'b0;
    else if (pend_en) kbd_en_nxt = 1'b1;
    ovf_nxt = ovf;
    if (pend_clr_ovf) ovf_nxt = 1'b0;
    if (drop)         ovf_nxt = 1'b1;
    irq_nxt = (level_nxt != '0) & kbd_en_nxt;
  end

  // Bus side: registered ack/data plus the side effects queued for the ack cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_ack_o     <= 1'b0;
      wb_dat_o     <= 16'h0000;
      pend_pop     <= 1'b0;
      pend_clr_ovf <= 1'b0;
      pend_dis     <= 1'b0;
      pend_en      <= 1'b0;
    end else begin
      wb_ack_o     <= (acc != ACC_NONE);
      wb_dat_o     <= dat_nxt;
      pend_pop     <= (acc == ACC_RD_DATA) & ~fifo_empty;
      pend_clr_ovf <= (acc == ACC_RD_STAT) & ovf;
      pend_dis     <= (acc == ACC_WR_STAT) && (wb_dat_i[7:0] == CMD_KBD_DIS);
      pend_en      <= (acc == ACC_WR_STAT) && (wb_dat_i[7:0] == CMD_KBD_EN);
    end
  end

  // Control state: enable, sticky overflow, interrupt level and last-read byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kbd_en    <= 1'b1;
      ovf       <= 1'b0;
      kbd_irq   <= 1'b0;
      data_hold <= 8'h00;
    end else begin
      kbd_en  <= kbd_en_nxt;
      ovf     <= ovf_nxt;
      kbd_irq <= irq_nxt;
      if (pop_ok) data_hold <= fifo_head;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_port.sv
// Scoreboard bench for ps2_kbd_port: reads queue their expected data,
// a negedge monitor compares whenever the DUT acks.
module tb_ps2_kbd_port;
  import ps2_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  scancode;
  logic        rx_output_strobe;
  logic [1:0]  wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        kbd_irq;
  logic [4:0]  fifo_level;

  typedef struct {
    logic        check;
    logic [15:0] exp;
    string       name;
  } sb_t;

  sb_t sb[$];
  int  errors = 0;
  int  checks = 0;

  always #5 clk = ~clk;

  ps2_kbd_port #(.FIFO_AW(4), .STATUS_SYS(1'b1)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .scancode         (scancode),
    .rx_output_strobe (rx_output_strobe),
    .wb_adr_i         (wb_adr_i),
    .wb_dat_i         (wb_dat_i),
    .wb_dat_o         (wb_dat_o),
    .wb_sel_i         (wb_sel_i),
    .wb_we_i          (wb_we_i),
    .wb_stb_i         (wb_stb_i),
    .wb_cyc_i         (wb_cyc_i),
    .wb_ack_o         (wb_ack_o),
    .kbd_irq          (kbd_irq),
    .fifo_level       (fifo_level)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ack consumes one scoreboard entry
  always @(negedge clk) begin
    if (reset_n === 1'b1 && wb_ack_o === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_ack", 32'(wb_ack_o), 32'h0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        if (e.check) checkOutput(e.name, 32'(wb_dat_o), 32'(e.exp));
      end
    end
  end

  task automatic busDrive(input logic we, input logic [1:0] adr, input logic [7:0] wdata);
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = {8'h00, wdata};
    wb_sel_i = 2'b11;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
  endtask

  task automatic busIdle();
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  // One bus access; returns #1 after the edge that raised ack (ack cycle)
  task automatic applyStimulus(input logic we, input logic [1:0] adr, input logic [7:0] wdata,
                               input logic chk, input logic [15:0] exp, input string name);
    sb_t e;
    bit  acked;
    e.check = chk;
    e.exp   = exp;
    e.name  = name;
    sb.push_back(e);
    @(posedge clk); #1;
    busDrive(we, adr, wdata);
    acked = 1'b0;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) acked = 1'b1;
    end
    busIdle();
    if (!acked) begin
      checkOutput({"ack_timeout_", name}, 32'h0, 32'h1);
      void'(sb.pop_back());
    end
  endtask

  task automatic strobeCode(input logic [7:0] code);
    @(posedge clk); #1;
    scancode         = code;
    rx_output_strobe = 1'b1;
    @(posedge clk); #1;
    rx_output_strobe = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    busIdle();
    rx_output_strobe = 1'b0;
    reset_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    scancode         = 8'h00;
    rx_output_strobe = 1'b0;
    wb_adr_i         = 2'b00;
    wb_dat_i         = 16'h0000;
    wb_sel_i         = 2'b11;
    busIdle();
    #1;
    checkOutput("rst_ack", 32'(wb_ack_o), 32'h0);
    checkOutput("rst_irq", 32'(kbd_irq), 32'h0);
    checkOutput("rst_level", 32'(fifo_level), 32'h0);
    checkOutput("rst_dat", 32'(wb_dat_o), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Basic two-byte transfer
    applyStimulus(1'b0, ADR_STAT, 8'h00, 1'b1, 16'h0014, "stat_idle");
    strobeCode(8'h1E);
    strobeCode(8'h30);
    checkOutput("lvl_two", 32'(fifo_level), 32'd2);
    checkOutput("irq_data", 32'(kbd_irq), 32'h1);
    applyStimulus(1'b0, ADR_STAT, 8'h00, 1'b1, 16'h0015, "stat_obf");
    applyStimulus(1'b0, ADR_DATA, 8'h00, 1'b1, 16'h001E, "rd_1e");
    checkOutput("lvl_ack_cycle", 32'(fifo_level), 32'd2);
    @(posedge clk); #1;
    checkOutput("lvl_after_pop", 32'(fifo_level), 32'd1);
    applyStimulus(1'b0, ADR_DATA, 8'h00, 1'b1, 16'h0030, "rd_30");
    checkOutput("irq_in_ack", 32'(kbd_irq), 32'h1);
    @(posedge clk); #1;
    checkOutput("irq_after_last", 32'(kbd_irq), 32'h0);
    checkOutput("lvl_empty", 32'(fifo_level), 32'd0);
    applyStimulus(1'b0, ADR_STAT, 8'h00, 1'b1, 16'h0014, "stat_empty");
    applyStimulus(1'b0, ADR_DATA, 8'h00, 1'b1, 16'h0030, "rd_hold");
    @(posedge clk); #1;
    checkOutput("lvl_hold", 32'(fifo_level), 32'd0);

    // Overflow and full-with-pop
    doReset();
    for (int i = 1; i <= 17; i++) strobeCode(8'(i));
    checkOutput("lvl_full", 32'(fifo_level), 32'd16);
    applyStimulus(1'b0, ADR_STAT, 8'h00, 1'b1, 16'h0095, "stat_ovf");
    applyStimulus(1'b0, ADR_STAT, 8'h00, 1'b1, 16'h0015, "stat_ovf_clr");
    begin
      sb_t e;
      e.check = 1'b1;
      e.exp   = 16'h0001;
      e.name  = "rd_full_pop";
      sb.push_back(e);
      @(posedge clk); #1;
      busDrive(1'b0, ADR_DATA, 8'h00);
      @(posedge clk); #1;
      checkOutput("ack_full_pop", 32'(wb_ack_o), 32'h1);
      busIdle();
      scancode         = 8'h55;
      rx_output_strobe = 1'b1;
      @(posedge clk); #1;
      rx_output_strobe = 1'b0;
      checkOutput("lvl_full_pop", 32'(fifo_level), 32'd16);
    end
    applyStimulus(1'b0, ADR_STAT, 8'h00, 1'b1, 16'h0015, "stat_no_ovf");
    for (int i = 2; i <= 16; i++) applyStimulus(1'b0, ADR_DATA, 8'h00, 1'b1, 16'(i), "rd_seq");
    applyStimulus(1'b0, ADR_DATA, 8'h00, 1'b1, 16'h0055, "rd_55");
    @(posedge clk); #1;
    checkOutput("lvl_drained", 32'(fifo_level), 32'd0);
    checkOutput("irq_drained", 32'(kbd_irq), 32'h0);

    // Disable / enable commands
    doReset();
    strobeCode(8'hA1);
    strobeCode(8'hA2);
    applyStimulus(1'b1, ADR_STAT, CMD_KBD_DIS, 1'b0, 16'h0000, "wr_dis");
    @(posedge clk); #1;
    checkOutput("irq_disabled", 32'(kbd_irq), 32'h0);
    applyStimulus(1'b0, ADR_STAT, 8'h00, 1'b1, 16'h0005, "stat_dis");
    strobeCode(8'h22);
    checkOutput("lvl_dis_drop", 32'(fifo_level), 32'd2);
    applyStimulus(1'b0, ADR_STAT, 8'h00, 1'b1, 16'h0005, "stat_dis_noovf");
    applyStimulus(1'b1, ADR_STAT, CMD_KBD_EN, 1'b0, 16'h0000, "wr_en");
    @(posedge clk); #1;
    checkOutput("irq_reenabled", 32'(kbd_irq), 32'h1);
    applyStimulus(1'b1, ADR_DATA, CMD_KBD_DIS, 1'b0, 16'h0000, "wr_data_port");
    applyStimulus(1'b0, ADR_STAT, 8'h00, 1'b1, 16'h0015, "stat_after_wr60");
    applyStimulus(1'b0, 2'b01, 8'h00, 1'b1, 16'h0000, "rd_unmapped");
    applyStimulus(1'b0, ADR_DATA, 8'h00, 1'b1, 16'h00A1, "rd_a1");
    applyStimulus(1'b0, ADR_DATA, 8'h00, 1'b1, 16'h00A2, "rd_a2");
    applyStimulus(1'b0, ADR_STAT, 8'h00, 1'b1, 16'h0014, "stat_final");

    // Reset in the middle of an access
    doReset();
    strobeCode(8'h11);
    strobeCode(8'h12);
    strobeCode(8'h13);
    checkOutput("lvl_three", 32'(fifo_level), 32'd3);
    @(posedge clk); #1;
    busDrive(1'b0, ADR_DATA, 8'h00);
    @(posedge clk); #1;
    checkOutput("ack_before_rst", 32'(wb_ack_o), 32'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_ack", 32'(wb_ack_o), 32'h0);
    checkOutput("rst_mid_irq", 32'(kbd_irq), 32'h0);
    checkOutput("rst_mid_level", 32'(fifo_level), 32'd0);
    busIdle();
    @(posedge clk); #1;
    reset_n = 1'b1;
    applyStimulus(1'b0, ADR_STAT, 8'h00, 1'b1, 16'h0014, "stat_post_rst");
    applyStimulus(1'b0, ADR_DATA, 8'h00, 1'b1, 16'h0000, "rd_post_rst");

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_drain", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_port.md
Name: ps2_kbd_port

Overview:
- 8042-style host-side front end that sits directly downstream of the PS/2 keyboard receiver.
- Captures each translated scancode on the receiver's output strobe into a FIFO and presents it on a 16-bit Wishbone slave as port 0x60 (data) and port 0x64 (status).
- Raises a level interrupt (IRQ1 source) while data is waiting.
- Accepts the 0xAD/0xAE disable/enable commands on port 0x64.

Parameters:
- FIFO_AW, 4, log2 of FIFO depth (16 entries).
- STATUS_SYS, 1, value reported in status bit 2 (system flag).

Ports:
- clk  input  1  system clock (same clock as the receiver).
- reset_n  input  1  asynchronous, active-low reset.
- scancode  input  8  translated scancode from the receiver.
- rx_output_strobe  input  1  one-cycle strobe; scancode is valid in the same cycle.
- wb_adr_i  input  2  address bits [2:1]: 2'b00 = port 0x60, 2'b10 = port 0x64, others are unmapped.
- wb_dat_i  input  16  write data; the low byte is used.
- wb_dat_o  output  16  read data; {8'h00, byte}.
- wb_sel_i  input  2  byte selects; an access counts only when wb_sel_i[0]=1.
- wb_we_i  input  1  write enable.
- wb_stb_i  input  1  strobe.
- wb_cyc_i  input  1  cycle.
- wb_ack_o  output  1  acknowledge.
- kbd_irq  output  1  interrupt request, level.
- fifo_level  output  FIFO_AW+1  current occupancy (debug).

Behaviour:
- Reset (async, reset_n=0):
  - FIFO empty; data_hold=8'h00; kbd_en=1; ovf=0.
  - wb_ack_o=0; wb_dat_o=16'h0000; kbd_irq=0; fifo_level=0.
- Wishbone:
  - Registered ack: wb_ack_o=1 in the cycle after wb_stb_i&wb_cyc_i&~wb_ack_o is seen; 0 in the following cycle.
  - Every access is acked in 1 wait state, including unmapped addresses.
  - wb_dat_o is registered and valid in the ack cycle.
  - Side effects occur in the cycle ack is asserted: exactly once per access.
- Read port 0x60:
  - FIFO non-empty: return head and pop; data_hold <= head.
  - FIFO empty: return data_hold; no pop.
- Read port 0x64: status byte.
  - bit0 OBF = ~empty.
  - bit1 IBF = 0.
  - bit2 = STATUS_SYS.
  - bit4 = kbd_en.
  - bit7 = ovf.
  - Other bits are 0.
  - A status read clears ovf after returning it.
- Write port 0x64:
  - 8'hAD → kbd_en=0.
  - 8'hAE → kbd_en=1.
  - Any other value is ignored.
- Write port 0x60: acked, ignored.
- Unmapped address read: returns 16'h0000.
- Push: rx_output_strobe & kbd_en.
  - Not full → write scancode at tail.
  - Full without simultaneous pop → drop the byte, set ovf=1 (sticky).
  - Full with simultaneous pop → accept the byte; the level is unchanged.
- Strobe while kbd_en=0: byte dropped, ovf unaffected.
- Simultaneous push and pop on a non-empty FIFO: both take effect; the level is unchanged.
- Simultaneous push and pop on an empty FIFO: not possible, because pop requires non-empty at the ack cycle. The pushed byte becomes visible the next cycle.
- Pointers: FIFO_AW+1 bits, wrap modulo 2^(FIFO_AW+1).
  - full = MSBs differ and the lower bits are equal.
  - empty = pointers equal.
- Latency:
  - A scancode strobed in cycle N is in the FIFO and reflected in OBF/kbd_irq at cycle N+1.
  - A port 0x60 read started at cycle M returns at M+1 and decrements fifo_level at M+2.
- kbd_irq = ~empty & kbd_en (registered).
  - It deasserts the cycle after the last byte is popped.
  - It deasserts immediately when disabled, and reasserts on 0xAE if data remains.
- Disabling does not flush the FIFO.
- Reset mid-transfer: ack is dropped immediately; the host must retry.

Decomposition:
- Shared package ps2_pkg:
  - port address codes (ADR_DATA=2'b00, ADR_STAT=2'b10);
  - command constants CMD_KBD_DIS=8'hAD, CMD_KBD_EN=8'hAE;
  - status bit indices (ST_OBF=0, ST_IBF=1, ST_SYS=2, ST_EN=4, ST_OVF=7).
- Sub-module ps2_kbd_fifo:
  - parameterised synchronous FIFO with push/pop/full/empty/level;
  - head read is combinational;
  - async active-low reset on the pointers.

Test Plan:
- Strobe scancodes 8'h1E, 8'h30 → status read returns 8'h15 (OBF, SYS, EN); kbd_irq=1. Port 0x60 reads return 16'h001E then 16'h0030. kbd_irq=0 the cycle after the second ack; status then reads 8'h14.
- Read 0x60 on an empty FIFO after the last pop of 8'h30 → returns 16'h0030, fifo_level stays 0, no ack stall.
- Push 17 codes 8'h01..8'h11 with no reads → fifo_level=16. Status bit7=1 on the first status read and 0 on the next. Reads return 8'h01..8'h10; 8'h11 is lost.
- With the FIFO full, strobe 8'h55 in the same cycle as a port 0x60 ack → 8'h55 accepted, ovf stays 0, fifo_level stays 16, 8'h55 is the last entry read.
- Write 8'hAD to 0x64 with 2 entries queued → kbd_irq=0, status bit4=0. Strobed 8'h22 is dropped and ovf stays 0. Write 8'hAE → kbd_irq=1 next cycle; 2 entries are read out.
- Assert reset_n=0 asynchronously mid-access with 3 entries queued → wb_ack_o, kbd_irq, fifo_level are 0 immediately. After release, status reads 8'h14 and a 0x60 read returns 16'h0000.
